// File: rtl/encoder_velocity.sv
// rtl/encoder_velocity.sv - windowed encoder velocity with moving average
module encoder_velocity #(
    parameter int WINDOW   = 50000,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] count,
    input  logic        zero_evt,
    output logic [15:0] velocity,
    output logic [15:0] avg_velocity,
    output logic        vel_valid,
    output logic        primed
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 16 + AVG_LOG2;
    localparam int TW    = $clog2(WINDOW);
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [TW-1:0] TICK_AT   = TW'(WINDOW - 1);
    localparam logic [FW-1:0] LAST_FILL = FW'(DEPTH - 1);
    localparam logic [FW-1:0] FULL_FILL = FW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_capture;
    logic                w_stop;
    logic                w_tick;

    logic [TW-1:0]       r_timer;
    logic [15:0]         r_prev;
    logic signed [15:0]  r_hist [DEPTH];
    logic signed [SW-1:0] r_sum;
    logic [FW-1:0]       r_fill;
    logic                r_discard;
    logic [15:0]         r_velocity;
    logic [15:0]         r_avg;
    logic                r_valid;
    logic                r_primed;

    logic signed [15:0]   w_delta;
    logic signed [SW-1:0] w_sum_next;

    // Modular subtraction makes position wrap-around come out as a small signed delta.
    assign w_delta    = signed'(count - r_prev);
    assign w_sum_next = r_sum + SW'(w_delta) - SW'(r_hist[DEPTH-1]);

    assign velocity     = r_velocity;
    assign avg_velocity = r_avg;
    assign vel_valid    = r_valid;
    assign primed       = r_primed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_stop       = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_stop       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_timer == TICK_AT) begin
                    w_tick = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_prev     <= '0;
            r_sum      <= '0;
            r_fill     <= '0;
            r_discard  <= 1'b0;
            r_velocity <= '0;
            r_avg      <= '0;
            r_valid    <= 1'b0;
            r_primed   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_prev    <= count;
                r_timer   <= '0;
                r_discard <= 1'b0;
            end else if (w_stop) begin
                // Outputs hold their last values; only the averaging state restarts.
                r_timer   <= '0;
                r_discard <= 1'b0;
                r_sum     <= '0;
                r_fill    <= '0;
                r_primed  <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_hist[i] <= '0;
                end
            end else if (w_tick) begin
                r_timer   <= '0;
                r_discard <= 1'b0;
                // A zero strobe on the tick means count goes to 0 next cycle.
                r_prev    <= zero_evt ? 16'h0000 : count;
                if (!zero_evt && !r_discard) begin
                    r_velocity <= w_delta;
                    r_valid    <= 1'b1;
                    r_sum      <= w_sum_next;
                    r_avg      <= 16'(w_sum_next >>> AVG_LOG2);
                    r_hist[0]  <= w_delta;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    if (r_fill != FULL_FILL) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    if (r_fill == LAST_FILL) begin
                        r_primed <= 1'b1;
                    end
                end
            end else if (r_state == S_RUN) begin
                r_timer <= r_timer + 1'b1;
                if (zero_evt) begin
                    r_discard <= 1'b1;
                end
            end
        end
    end
endmodule
